// File: rtl/sm_uart_tx_mm_if.sv
`default_nettype none
// ============================================================================
// Module : sm_uart_tx_mm_if
// Brief  : Data-memory bus slice seen by the memory-mapped UART transmitter.
// Rev    : 1.0  initial release
// ============================================================================
interface sm_uart_tx_mm_if;
  logic        sel;
  logic [3:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (
    output sel,
    output addr,
    output we,
    output wd,
    input  rd
  );

  modport slave (
    input  sel,
    input  addr,
    input  we,
    input  wd,
    output rd
  );
endinterface
`default_nettype wire

// File: rtl/sm_uart_tx_mm.sv
`default_nettype none
// ============================================================================
// Module : sm_uart_tx_mm
// Brief  : Memory-mapped 8N1 UART transmitter with TX FIFO and divisor timer.
//          Optional interrupt controller enabled by macro SM_UART_IRQ_EN.
// Rev    : 1.0  initial release
// ============================================================================
module sm_uart_tx_mm #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          FIFO_AW    = 3,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic           clk,
  input  logic           rst_n,
  sm_uart_tx_mm_if.slave bus,
  output logic           tx,
  output logic           irq
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  localparam logic [1:0] c_REG_TXDATA = 2'd0;
  localparam logic [1:0] c_REG_STATUS = 2'd1;
  localparam logic [1:0] c_REG_DIV    = 2'd2;
  localparam logic [1:0] c_REG_IRQCTL = 2'd3;

  localparam logic [FIFO_AW:0] c_FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic w_wrEn;
  logic w_wrTx;
  logic w_wrStat;
  logic w_wrDiv;

  assign w_wrEn   = bus.sel & bus.we;
  assign w_wrTx   = w_wrEn & (bus.addr[3:2] == c_REG_TXDATA);
  assign w_wrStat = w_wrEn & (bus.addr[3:2] == c_REG_STATUS);
  assign w_wrDiv  = w_wrEn & (bus.addr[3:2] == c_REG_DIV);

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr;
  logic [FIFO_AW-1:0] r_rdPtr;
  logic [FIFO_AW:0]   r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_ovfSet;
  logic [7:0]         w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL_CNT);
  assign w_head   = r_mem[r_rdPtr];
  // A push into a full FIFO is still legal when the FSM frees a slot this cycle.
  assign w_push   = w_wrTx & (~w_full | w_pop);
  assign w_ovfSet = w_wrTx & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= bus.wd[7:0];
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [15:0] r_divisor;
  logic        r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divisor <= DIV_RESET;
    end else if (w_wrDiv) begin
      r_divisor <= bus.wd[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovfSet) begin
      r_ovf <= 1'b1;
    end else if (w_wrStat & bus.wd[3]) begin
      r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit timer and serialiser FSM
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitIdx;
  logic [15:0] r_bitCnt;
  logic        r_tx;
  logic        w_tick;

  assign w_tick = (r_bitCnt == '0);
  assign w_pop  = ~w_empty & ((r_state == c_IDLE) | ((r_state == c_STOP) & w_tick));

  // The timer reloads from r_divisor only at bit boundaries, so a divisor
  // write never alters the bit currently on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_bitCnt <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_state  <= c_START;
            r_shift  <= w_head;
            r_bitCnt <= r_divisor;
            r_tx     <= 1'b0;
          end
        end
        c_START: begin
          if (w_tick) begin
            r_state  <= c_DATA;
            r_bitIdx <= '0;
            r_bitCnt <= r_divisor;
            r_tx     <= r_shift[0];
          end else begin
            r_bitCnt <= r_bitCnt - 1'b1;
          end
        end
        c_DATA: begin
          if (w_tick) begin
            r_shift  <= r_shift >> 1;
            r_bitIdx <= r_bitIdx + 1'b1;
            r_bitCnt <= r_divisor;
            if (r_bitIdx == 3'd7) begin
              r_state <= c_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx    <= r_shift[1];
            end
          end else begin
            r_bitCnt <= r_bitCnt - 1'b1;
          end
        end
        c_STOP: begin
          if (w_tick) begin
            r_bitCnt <= r_divisor;
            if (w_pop) begin
              r_state <= c_START;
              r_shift <= w_head;
              r_tx    <= 1'b0;
            end else begin
              r_state <= c_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_bitCnt <= r_bitCnt - 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = r_tx;

  // ---------------------------------------------------------------------------
  // Interrupt controller
  // ---------------------------------------------------------------------------
  logic [31:0] w_irqCtlRd;

`ifdef SM_UART_IRQ_EN
  logic       w_wrIrq;
  logic [1:0] r_irqEn;
  logic       r_irq;

  assign w_wrIrq = w_wrEn & (bus.addr[3:2] == c_REG_IRQCTL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqEn <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wrIrq) r_irqEn <= bus.wd[1:0];
      r_irq <= (r_irqEn[0] & w_empty & (r_state == c_IDLE)) | (r_irqEn[1] & r_ovf);
    end
  end

  assign irq        = r_irq;
  assign w_irqCtlRd = {30'd0, r_irqEn};
`else
  assign irq        = 1'b0;
  assign w_irqCtlRd = '0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_status;
  logic [31:0] w_rd;
  logic        w_busy;

  assign w_busy = (r_state != c_IDLE) | ~w_empty;

  always_comb begin
    w_status                  = '0;
    w_status[0]               = w_busy;
    w_status[1]               = w_full;
    w_status[2]               = w_empty;
    w_status[3]               = r_ovf;
    w_status[8 +: FIFO_AW+1]  = r_count;
  end

  always_comb begin
    w_rd = '0;
    if (bus.sel) begin
      case (bus.addr[3:2])
        c_REG_STATUS: w_rd = w_status;
        c_REG_DIV:    w_rd = {16'd0, r_divisor};
        c_REG_IRQCTL: w_rd = w_irqCtlRd;
        default:      w_rd = '0;
      endcase
    end
  end

  assign bus.rd = w_rd;

  // Bus bits with no register behind them.
  logic w_unused;
  assign w_unused = ^{bus.wd[31:16], bus.addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sm_uart_tx_mm.sv
`default_nettype none
// Bench for sm_uart_tx_mm: bit-list reference model checked every cycle plus
// directed register/latency expectations. Honours SM_UART_IRQ_EN when defined.
module tb_sm_uart_tx_mm;

`ifdef SM_UART_IRQ_EN
  localparam bit c_IRQ = 1'b1;
`else
  localparam bit c_IRQ = 1'b0;
`endif
  localparam int c_DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic irq;

  sm_uart_tx_mm_if bus();

  sm_uart_tx_mm #(
    .FIFO_DEPTH (8),
    .FIFO_AW    (3),
    .DIV_RESET  (16'd433)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: line as a list of timed bits ----------
  byte unsigned mFifo[$];
  bit           mBits[$];
  int           mRemain;
  bit           mCur;
  logic [15:0]  mDiv;
  bit           mOvf;
  bit [1:0]     mIrqEn;
  bit           mIrq;

  task automatic modelReset();
    mFifo.delete();
    mBits.delete();
    mRemain = 0;
    mCur    = 1'b1;
    mDiv    = 16'd433;
    mOvf    = 1'b0;
    mIrqEn  = 2'b00;
    mIrq    = 1'b0;
  endtask

  task automatic startFrame(input logic [7:0] b);
    mBits.delete();
    for (int i = 0; i < 8; i++) mBits.push_back(b[i]);
    mBits.push_back(1'b1);
    mCur    = 1'b0;
    mRemain = int'(mDiv) + 1;
  endtask

  task automatic modelStep();
    int sizeBefore;
    bit popped;
    bit irqNext;
    bit ovfSet;
    bit ovfClr;
    sizeBefore = mFifo.size();
    popped = 0; ovfSet = 0; ovfClr = 0;
    irqNext = (mIrqEn[0] && sizeBefore == 0 && mRemain == 0) || (mIrqEn[1] && mOvf);
    if (mRemain > 1) mRemain--;
    else if (mRemain == 1 && mBits.size() > 0) begin
      mCur    = mBits.pop_front();
      mRemain = int'(mDiv) + 1;
    end else if (sizeBefore > 0) begin
      startFrame(mFifo.pop_front());
      popped = 1;
    end else mRemain = 0;
    if (bus.sel && bus.we) begin
      case (bus.addr[3:2])
        2'd0: if (sizeBefore < c_DEPTH || popped) mFifo.push_back(bus.wd[7:0]); else ovfSet = 1;
        2'd1: ovfClr = bus.wd[3];
        2'd2: mDiv = bus.wd[15:0];
        default: if (c_IRQ) mIrqEn = bus.wd[1:0];
      endcase
    end
    if (ovfSet) mOvf = 1'b1;
    else if (ovfClr) mOvf = 1'b0;
    mIrq = c_IRQ && irqNext;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ------------
  task automatic tick();
    @(negedge clk);
    check("tx_cycle", tx, (mRemain > 0) ? mCur : 1'b1);
    check("irq_cycle", irq, mIrq);
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wd = d;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    check(name, bus.rd, exp);
    bus.sel = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < limit) begin
      bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 4'h4;
      #1;
      done = (bus.rd[0] == 1'b0);
      bus.sel = 1'b0;
      if (!done) begin
        tick();
        n++;
      end
    end
    check("wait_idle", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  logic [63:0] samp;
  logic [63:0] expv;
  logic [9:0]  patA;
  logic [9:0]  patB;

  initial begin
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.wd = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b0);
    busRead(4'h4, 32'h0000_0004, "reset_status");
    busRead(4'h8, 32'h0000_01B1, "reset_divisor");
    busRead(4'hC, 32'h0, "reset_irqctl");
    rst_n = 1'b1;
    tick(); tick();

    bus.sel = 1'b0; bus.addr = 4'h8;
    #1;
    check("rd_unselected", bus.rd, 32'h0);
    busRead(4'h0, 32'h0, "txdata_reads_zero");

    // Frame 0xA5 at 4 clocks per bit
    busWrite(4'h8, 32'd3);
    busWrite(4'h0, 32'hA5);
    check("t1_latency_tx_high", tx, 1'b1);
    patA = 10'b1_1010_0101_0;
    samp = '0; expv = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      samp[i] = tx;
      expv[i] = patA[i/4];
      if (i == 20) busRead(4'h4, 32'h0000_0005, "t1_busy_mid_frame");
    end
    check("t1_frame_a5", samp, expv);
    tick();
    busRead(4'h4, 32'h0000_0004, "t1_idle_status");

    // Back-to-back 0x55, 0x0F at 2 clocks per bit: 40 clocks, no gap
    busWrite(4'h8, 32'd1);
    busWrite(4'h0, 32'h55);
    busWrite(4'h0, 32'h0F);
    busRead(4'h4, 32'h0000_0101, "t2_count_one");
    patA = 10'b1_0101_0101_0;
    patB = 10'b1_0000_1111_0;
    samp = '0; expv = '0;
    samp[0] = tx;
    expv[0] = patA[0];
    for (int i = 1; i < 40; i++) begin
      tick();
      samp[i] = tx;
      expv[i] = (i < 20) ? patA[i/2] : patB[(i-20)/2];
    end
    check("t2_two_frames", samp, expv);
    tick();
    busRead(4'h4, 32'h0000_0004, "t2_idle_status");

    // Divisor 7 -> 0 written during frame bit 3
    busWrite(4'h8, 32'd7);
    busWrite(4'h0, 32'h55);
    samp = '0; expv = '0;
    for (int i = 0; i < 39; i++) begin
      tick();
      samp[i] = tx;
      if (i < 32)      expv[i] = patA[i/8];
      else if (i < 38) expv[i] = patA[4 + i - 32];
      else             expv[i] = 1'b1;
      if (i == 26) begin
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 4'h8; bus.wd = 32'd0;
      end
      if (i == 27) begin
        bus.sel = 1'b0; bus.we = 1'b0;
      end
    end
    check("t5_divisor_change", samp, expv);
    busRead(4'h4, 32'h0000_0004, "t5_idle_status");
    busRead(4'h8, 32'h0, "t5_div_zero");

    // Interrupt behaviour (irq stays low without the feature)
    busWrite(4'hC, 32'd1);
    tick();
    check("t6_irq_idle_empty", irq, c_IRQ);
    busRead(4'hC, {31'd0, c_IRQ}, "t6_irqctl_read");
    busWrite(4'h0, 32'h3C);
    check("t6_irq_hold", irq, c_IRQ);
    tick();
    check("t6_irq_busy_low", irq, 1'b0);
    waitIdle(50);
    busWrite(4'hC, 32'd2);
    for (int i = 0; i < 10; i++) busWrite(4'h0, 32'h10 + i);
    tick();
    check("t6_irq_ovf", irq, c_IRQ);
    busRead(4'h4, 32'h0000_080B, "t6_ovf_status");
    busWrite(4'h4, 32'h8);
    check("t6_irq_ovf_hold", irq, c_IRQ);
    tick();
    check("t6_irq_ovf_cleared", irq, 1'b0);
    busRead(4'h4, 32'h0000_0701, "t6_status_after_clear");
    waitIdle(200);
    busWrite(4'hC, 32'd0);

    // Fill and overflow at divisor 100
    busWrite(4'h8, 32'd100);
    for (int i = 0; i < 9; i++) busWrite(4'h0, 32'h0);
    busRead(4'h4, 32'h0000_0803, "t3_full");
    busWrite(4'h0, 32'hFF);
    busRead(4'h4, 32'h0000_080B, "t3_ovf_set");
    busWrite(4'h4, 32'h8);
    busRead(4'h4, 32'h0000_0803, "t3_ovf_cleared");

    // Asynchronous reset in the middle of the data bits
    repeat (300) tick();
    check("t4_tx_low_in_data", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_tx_async_high", tx, 1'b1);
    check("t4_irq_reset", irq, 1'b0);
    busRead(4'h4, 32'h0000_0004, "t4_status_reset");
    busRead(4'h8, 32'h0000_01B1, "t4_divisor_reset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    busRead(4'h4, 32'h0000_0004, "t4_after_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
